// File: rtl/fp_serial_tx_if.sv
// fp_serial_tx_if: valid/ready handshake carrying converter S/E/F words into fp_serial_tx.
interface fp_serial_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       S;
    logic [2:0] E;
    logic [4:0] F;
    modport master(output in_valid, S, E, F, input in_ready);
    modport slave(input in_valid, S, E, F, output in_ready);
endinterface

// File: rtl/fp_serial_tx.sv
// fp_serial_tx: FIFO-buffered UART-style transmitter for 9-bit FP words, LSB first, even parity.
module fp_serial_tx #(
    parameter int DEPTH = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fp_serial_tx_if.slave              in_if,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BW-1:0] baud;
    logic [3:0]    idx;
    logic [8:0]    sh;
    logic          push, pop, bit_end;
    assign in_if.in_ready = count < CW'(DEPTH);
    assign busy = state != IDLE;
    assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
    assign push = in_if.in_valid && in_if.in_ready;
    // a pop either leaves IDLE or chains the next frame straight after a stop bit
    assign pop = count != '0 && (state == IDLE || (state == STOP && bit_end));
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_if.S, in_if.E, in_if.F};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tx     <= 1'b1;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            baud   <= '0;
            idx    <= '0;
            sh     <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                sh     <= mem[rd_ptr];
            end
            baud <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
            case (state)
                IDLE: begin
                    tx <= !pop;
                    if (pop) state <= START;
                end
                START: if (bit_end) begin
                    tx    <= sh[0];
                    idx   <= '0;
                    state <= DATA;
                end
                DATA: if (bit_end) begin
                    if (idx == 4'd8) begin
                        tx    <= ^sh;
                        state <= PARITY;
                    end else begin
                        idx <= idx + 4'd1;
                        tx  <= sh[idx + 4'd1];
                    end
                end
                PARITY: if (bit_end) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
                STOP: if (bit_end) begin
                    tx    <= !pop;
                    state <= pop ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_serial_tx.sv
// tb_fp_serial_tx: directed steps with a frame scoreboard fed at the handshake and drained by a line monitor.
module tb_fp_serial_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx, busy;
    logic [2:0] count;
    int         n_vec = 0;
    int         n_err = 0;
    logic [11:0] sb[$];

    fp_serial_tx_if bif();
    fp_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .in_if(bif), .tx(tx), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] frame_of(input logic [8:0] w);
        return {1'b1, ^w, w, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [8:0] w);
        {bif.S, bif.E, bif.F} = w;
        bif.in_valid = 1'b1;
    endtask

    task automatic busy_len(input string tag, input int exp);
        int c = 0;
        while (busy && c < 400) begin
            step();
            c++;
        end
        chk(tag, c, exp);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 2000) begin
            step();
            c++;
        end
        chk("idle_timeout", busy, 0);
        step(4);
    endtask

    always @(posedge clk)
        if (!rst && bif.in_valid && bif.in_ready)
            sb.push_back(frame_of({bif.S, bif.E, bif.F}));

    // samples every cycle of a frame so a glitch inside any bit also shows up
    initial begin : mon
        logic [47:0] got, exp;
        logic [11:0] f;
        bit          ab;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ab = 0;
                got[0] = tx;
                for (int i = 1; i < 48; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1;
                        break;
                    end
                    got[i] = tx;
                end
                if (!ab) begin
                    exp = 'x;
                    if (sb.size() != 0) begin
                        f = sb.pop_front();
                        for (int i = 0; i < 48; i++) exp[i] = f[i / CPB];
                    end
                    chk("frame", got, exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] a;
        int fill_exp[5] = '{1, 1, 2, 3, 4};
        rst = 1'b1;
        bif.in_valid = 1'b0;
        put(9'h1AB);
        step(2);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", bif.in_ready, 1);
        rst = 1'b0;
        bif.in_valid = 1'b0;
        step();
        chk("rst_no_enq", count, 0);
        chk("idle_tx", tx, 1);

        put(9'b1_101_10011);
        step();
        bif.in_valid = 1'b0;
        chk("lat_count", count, 1);
        chk("lat_tx_hi", tx, 1);
        step();
        chk("lat_tx_lo", tx, 0);
        chk("lat_busy", busy, 1);
        busy_len("single_busy", 48);
        step(4);

        for (int i = 0; i < 5; i++) begin
            put(9'(9'h05A + i * 77));
            step();
            chk("fill_count", count, fill_exp[i]);
        end
        chk("fill_ready", bif.in_ready, 0);
        put(9'h133);
        step(44);
        chk("full_hold_count", count, 4);
        chk("full_hold_ready", bif.in_ready, 0);
        step();
        chk("full_pop_count", count, 3);
        chk("full_pop_ready", bif.in_ready, 1);
        step();
        bif.in_valid = 1'b0;
        chk("full_refill_count", count, 4);
        chk("full_refill_ready", bif.in_ready, 0);
        wait_idle();

        put(9'h0F0);
        step();
        put(9'h10F);
        step();
        bif.in_valid = 1'b0;
        chk("b2b_busy_rise", busy, 1);
        busy_len("b2b_busy", 96);
        step(4);

        a = 9'b0_011_01000;
        put(a);
        step();
        put(9'h1C3);
        step();
        put(9'h02D);
        step();
        bif.in_valid = 1'b0;
        chk("mid_count", count, 2);
        step(16);
        chk("mid_bit3", tx, a[3]);
        rst = 1'b1;
        sb.delete();
        step();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bif.in_ready, 1);
        rst = 1'b0;
        step();
        put(9'h155);
        step();
        bif.in_valid = 1'b0;
        chk("post_lat_hi", tx, 1);
        step();
        chk("post_lat_lo", tx, 0);
        busy_len("post_busy", 48);
        step(4);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_serial_tx.md
# fp_serial_tx

Serial transmitter for the 9-bit floating-point words (sign, 3-bit exponent, 5-bit significand) produced by the linear-to-FP converter stage. Converted samples are pushed through a valid/ready handshake into a small FIFO. Each sample is sent on a single-wire, UART-style framed line with even parity. The block sits directly downstream of the converter and is the sole consumer of its S/E/F outputs.

## Interface
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CLKS_PER_BIT, 4: clock cycles per serial bit; >= 1.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  S/E/F hold a word to enqueue.
- in_ready  output  1  FIFO can accept; equals (count < DEPTH).
- S  input  1  sign bit from converter.
- E  input  3  exponent from converter.
- F  input  5  significand from converter.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high whenever state != IDLE.
- count  output  clog2(DEPTH+1)  FIFO occupancy.

## Operation
- **Word packing:** word[8:0] = {S, E, F}.
- **Transmit order, LSB first:** F[0..4], then E[0..2], then S.
- **Frame (12 bits):**
  - start = 0
  - 9 data bits
  - parity = XOR of the 9 data bits (even parity)
  - stop = 1
- **Enqueue:** occurs on an edge where in_valid && in_ready.
  - Data is written at the write pointer.
  - The write pointer wraps modulo DEPTH.
- **Pop (dequeue):** head entry moves into the shift register and the read pointer wraps modulo DEPTH.
- **Occupancy:** count += push, count -= pop. A simultaneous push and pop leaves count unchanged.
- **in_ready:** depends only on the registered count.
  - When count == DEPTH, no push occurs even if a pop happens on the same edge.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Baud counter:**
  - Runs 0..CLKS_PER_BIT-1 in every state except IDLE.
  - A bit ends when the counter reaches CLKS_PER_BIT-1.
  - The counter then returns to 0.
- **FSM transitions:**
  - IDLE: if count != 0, pop, set tx <= 0, go to START. Otherwise tx = 1.
  - START: at bit end, tx <= data bit 0, go to DATA, bit index = 0.
  - DATA: at bit end, if index == 8, tx <= parity and go to PARITY. Otherwise index++ and tx <= next data bit.
  - PARITY: at bit end, tx <= 1, go to STOP.
  - STOP at bit end:
    - If count != 0: pop, tx <= 0, go to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Parity is computed from the shift-register copy, not from the live S/E/F inputs.
- **S/E/F sampling:** inputs are sampled only on push edges. Changes at any other time have no effect.
- **Reset (any state, including mid-frame):**
  - tx = 1, busy = 0, count = 0, in_ready = 1.
  - Pointers = 0, state = IDLE, baud counter = 0.
  - Queued words are discarded.

## Timing
- **Reset values:** tx = 1, busy = 0, count = 0, in_ready = 1.
- **Latency, idle and empty:** word accepted at edge E0 gives count = 1 after E0. Pop occurs at E1, and tx falls after E1, i.e. 2 cycles.
- **Frame length:** 12*CLKS_PER_BIT cycles, measured from the tx falling edge to the next START or IDLE entry.
- **Throughput:** one frame per 12*CLKS_PER_BIT cycles when the FIFO is non-empty.
- **busy:**
  - Rises on the pop edge out of IDLE.
  - Falls on the edge where STOP ends with the FIFO empty.
- **Output timing:** all outputs are registered or derived from registers only. There are no combinational input-to-output paths.

## Test plan
- **Reset:** hold rst 2 cycles with in_valid = 1 → tx = 1, busy = 0, count = 0, in_ready = 1, and nothing is enqueued during reset.
- **Single word, CLKS_PER_BIT = 4:** push S = 1, E = 3'b101, F = 5'b10011.
  - tx falls 2 cycles after the accept edge.
  - Bits are 0 | 1,1,0,0,1 | 1,0,1 | 1 | parity 0 | 1, each held 4 cycles.
  - busy lasts 48 cycles.
- **Fill from idle, DEPTH = 4, in_valid held high:**
  - Accepts occur at E0..E4, 5 words total; the E1 push coincides with a pop.
  - count = 4 and in_ready = 0 after E4.
  - The 6th word is accepted on the edge after the STOP-end pop of frame 1.
- **Back-to-back:** push 2 words → the second start bit immediately follows the first stop bit.
  - busy is continuous for 96 cycles with CLKS_PER_BIT = 4.
- **Full with simultaneous pop:** count = 4, in_valid = 1 on the STOP-end edge.
  - The pop occurs and there is no push, so count = 3.
  - The word is accepted on the following edge, giving count = 4.
- **Reset mid-frame:** assert rst during data bit 3 with 2 words queued.
  - tx = 1 and count = 0 after that edge.
  - A new push after reset produces a correct full frame, 2-cycle latency.
